// File: rtl/mc_controller_fsm_if.sv
// Control bundle between the multicycle controller and the shared RV32I datapath.
// master = controller side, slave = datapath side.
interface mc_controller_fsm_if;
    logic [6:0] op;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  op, Zero, MemReady,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, State
    );

    modport slave (
        output op, Zero, MemReady,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, State
    );
endinterface

// File: rtl/mc_controller_fsm.sv
// Moore control FSM for the multicycle RV32I core (Fetch/Decode/Execute/Writeback).
// Optional MCCTRL_MEMWAIT_EN: FETCH, MEMREAD and MEMWRITE stall until MemReady.
module mc_controller_fsm (
    input  logic                clk,
    input  logic                reset,
    mc_controller_fsm_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t     state, state_next, cur;
    logic       mem_ready;
    logic       pc_update, branch, illegal;
    logic       adr_src, ir_write, mem_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

`ifdef MCCTRL_MEMWAIT_EN
    assign mem_ready = bus.MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // While reset is high the outputs already show FETCH, so decode that instead of the stale register.
    assign cur = reset ? FETCH : state;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, otherwise unlisted paths infer latches.
    always_comb begin
        state_next = FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (cur)
            FETCH: begin
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_next = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_JAL:       state_next = JAL;
                    OP_BEQ:       state_next = BEQ;
                    default:      illegal    = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                state_next = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                state_next = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: reg_write = 1'b1;
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
                state_next = ALUWB;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    // Write enables are squashed during reset so an aborted instruction leaves no side effects.
    assign bus.PCWrite   = ~reset & (pc_update | (branch & bus.Zero));
    assign bus.IRWrite   = ~reset & ir_write;
    assign bus.MemWrite  = ~reset & mem_write;
    assign bus.RegWrite  = ~reset & reg_write;
    assign bus.Illegal   = ~reset & illegal;
    assign bus.AdrSrc    = adr_src;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.State     = cur;

endmodule

// File: doc/mc_controller_fsm.md
# mc_controller_fsm

Multicycle control unit for the RV32I core. Sequences the shared datapath (one memory for instructions and data, one ALU also used for PC+4 and branch targets) through Fetch/Decode/Execute/Writeback steps. It is a Moore FSM whose state register replaces single-cycle decoding. It sits beside the ALU decoder, which still consumes ALUOp.

## Interface
Parameters: none.

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- op  input  7  opcode, IR[6:0], valid from DECODE onward
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory access complete (used only with MCCTRL_MEMWAIT_EN)
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
- IRWrite  output  1  instruction/OldPC register enable
- MemWrite  output  1  memory write strobe
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4
- ALUOp  output  2  00 add, 01 subtract/compare, 10 funct-decoded
- ImmSrc  output  2  combinational from op: lw/I-type 00, sw 01, beq 10, jal 11, others 00
- Illegal  output  1  one-cycle pulse on an unsupported opcode
- State  output  4  current state, for debug

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Codes 11–15 are unreachable; if entered, the next state is FETCH and all enables are 0.
- Unlisted outputs are 0 in every state.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100011 → BEQ
  - otherwise → FETCH with Illegal=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=0000011, else to MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state is FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next state is FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next state is ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero. Next state is FETCH.
- PCWrite = PCUpdate | (Branch & Zero). Zero is sampled combinationally in BEQ only.

## Timing
- All outputs are a combinational decode of the registered state (Moore), except:
  - ImmSrc, which depends only on op;
  - PCWrite in BEQ, which also depends on Zero.
- Cycles per instruction with zero wait: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
- Reset: while reset=1, the next state is FETCH.
  - PCWrite, IRWrite, RegWrite, MemWrite and Illegal are forced to 0.
  - The mux selects show their FETCH values; State=0.
  - Reset asserted mid-instruction aborts it at the next edge; no write enable is asserted in the reset cycle.
- First FETCH enables are active in the cycle after reset deasserts.
- Illegal asserts only in the DECODE cycle and never in two consecutive cycles.

## Configuration
- MCCTRL_MEMWAIT_EN defined: FETCH, MEMREAD and MEMWRITE hold while MemReady=0.
  - In a held FETCH, IRWrite=0 and PCWrite=0; both assert only in the cycle where MemReady=1.
  - In a held MEMWRITE, MemWrite stays 1 and the state advances when MemReady=1.
  - Each wait cycle adds one cycle to the instruction.
- MCCTRL_MEMWAIT_EN undefined: MemReady is ignored, behaving as if it were tied to 1. CPIs are exactly those listed in Timing.

## Test plan
- Reset for 3 cycles, then op=0000011 (lw), Zero=0 → State sequence 0,1,2,3,4,0. RegWrite=1 only in state 4 with ResultSrc=01. PCWrite=1 only in state 0.
- op=0100011 (sw) → State sequence 0,1,2,5,0. MemWrite=1 only in state 5 with AdrSrc=1. ImmSrc=01 throughout.
- op=1100011 (beq):
  - Zero=1 → PCWrite=1 in state 10 with ALUOp=01; 3 cycles total.
  - Zero=0 → PCWrite=0 in state 10.
- op=1101111 (jal) → State sequence 0,1,9,7,0. PCWrite=1 in states 0 and 9. RegWrite=1 in state 7.
- op=1111111 → Illegal=1 for exactly the one DECODE cycle, then State=0. No RegWrite or MemWrite is asserted.
- With MCCTRL_MEMWAIT_EN, op=0000011 and MemReady=0 for 2 cycles in FETCH and in MEMREAD → lw takes 9 cycles, and IRWrite pulses once. Asserting reset in state 3 gives State=0 next cycle with all enables 0.
